simo_fifo: RTL and testbench
============================

Name: simo_fifo

Overview:
Single Input Multiple Output (SIMO) FIFO: the complement of the router's multi-input, single-output FIFO. It accepts one DATA_WIDTH word per cycle from a serial producer (flash router output or DMA stream) and releases a full row of DATA_LENGTH words in one pop. The row output drives the systolic-array row-loading path. It buffers serial traffic and regroups it into lane-parallel vectors with per-lane valid flags.

Parameters:
DEPTH, 32, storage words; power of two, DEPTH >= DATA_LENGTH
DATA_WIDTH, 8, bits per word
DATA_LENGTH, 9, lanes per output row
ADDR_WIDTH, $clog2(DEPTH), read/write pointer width
COUNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_clear  in  1  synchronous clear of pointers, count and outputs
i_write_en  in  1  write request for i_data
i_data  in  DATA_WIDTH  word to enqueue
i_pop_en  in  1  request to pop one row
i_flush  in  1  qualifies i_pop_en to allow a partial row (fewer than DATA_LENGTH words)
o_data  out  [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  popped row; lane k is the k-th oldest word
o_valid  out  DATA_LENGTH  per-lane valid mask of the last pop
o_out_valid  out  1  one-cycle pulse: o_data/o_valid updated
o_count  out  COUNT_WIDTH  current occupancy
o_row_avail  out  1  o_count >= DATA_LENGTH
o_empty  out  1  o_count == 0
o_full  out  1  o_count == DEPTH

Behaviour:
- Reset (i_rst high, asynchronous): w_ptr, r_ptr and count = 0; o_data all 0; o_valid = 0; o_out_valid = 0. This applies mid-operation as well: any in-flight pop is discarded. Storage contents are not reset.
- i_clear has the same effect as reset but is sampled on the clock edge. It has priority over write and pop in the same cycle.
- Write accepted iff i_write_en && !o_full, where o_full is evaluated on the pre-edge count. A pop in the same cycle does not free space for the write. On accept: mem[w_ptr] <= i_data; w_ptr += 1 (mod DEPTH). A rejected write is silently dropped with no state change.
- Pop size n:
  - If i_pop_en and count >= DATA_LENGTH: n = DATA_LENGTH.
  - Else if i_pop_en && i_flush && count > 0: n = count.
  - Otherwise n = 0, and the pop is ignored with no state change and no pulse.
- Pop with n > 0 has registered output, one-cycle latency. At the next edge:
  - o_data[k] = mem[(r_ptr+k) mod DEPTH] for k < n, and 0 for k >= n.
  - o_valid[k] = (k < n).
  - o_out_valid = 1; r_ptr += n (mod DEPTH).
- o_data and o_valid hold between pops. o_out_valid is 0 in every cycle without an accepted pop.
- Simultaneous accepted write and pop:
  - The pop reads pre-edge contents only; the word written this cycle is not visible to this pop.
  - count_next = count + w - n, where w is 1 if the write is accepted.
- Pointer wrap: natural modulo-DEPTH overflow of ADDR_WIDTH pointers. Rows may straddle the wrap point.
- Status outputs (o_count, o_row_avail, o_empty, o_full) are combinational from the count register.
- Full vs empty is decided only by count, never by pointer comparison.

Decomposition:
- router_pkg (shared) holds:
  - typedef word_t (logic [DATA_WIDTH-1:0]);
  - typedef row_t (word_t [0:DATA_LENGTH-1]);
  - default localparams for DATA_WIDTH and DATA_LENGTH, shared with the MISO FIFO.
- One sub-module is natural: simo_fifo_mem, a DEPTH x DATA_WIDTH register file with 1 write port and DATA_LENGTH combinational read ports addressed from r_ptr+k.
- Pointer, count and pop-size logic stay in the top module.

Test Plan:
1. Reset and clear: write 4 words, assert i_rst for 1 cycle mid-pop -> o_count=0, o_empty=1, o_valid=0, o_out_valid=0. Repeat using i_clear asserted together with i_write_en and i_pop_en -> clear wins and count stays 0.
2. Full row: write 0x01..0x09, then pulse i_pop_en -> next cycle o_data=01..09, o_valid=0x1FF, o_out_valid=1 for exactly 1 cycle, o_count=0.
3. Partial and flush: write 0xA0..0xA4, then i_pop_en without i_flush -> ignored, o_count=5. Then i_pop_en with i_flush -> lanes 0-4 = A0..A4, lanes 5-8 = 0, o_valid=0x01F.
4. Full boundary: write 33 words 0x00..0x20 -> o_full=1, o_count=32, 0x20 dropped. Pop 3 rows -> 0x00..0x1A in order, o_count=5.
5. Wrap-around: write 27 words and pop 3 rows (r_ptr=27), then write 0x50..0x58 (w_ptr wraps to 4) and pop -> o_data=50..58 in lane order.
6. Simultaneous: with count=9 (0x10..0x18), write 0x77 and pop in the same cycle -> row 10..18, o_count=1; the next flush pop returns lane 0 = 0x77, o_valid=0x001.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: word and row containers used by the SIMO/MISO FIFOs.
// Holds the default lane width and lane count for both FIFOs.
package router_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int DATA_LENGTH_DEF = 9;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef word_t [0:DATA_LENGTH_DEF-1] row_t;

endpackage

// File: rtl/simo_fifo_if.sv
// SIMO FIFO bus: serial write side, row pop side and occupancy status.
// master = producer/consumer driving requests, slave = the FIFO itself.
interface simo_fifo_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 9,
    parameter int COUNT_WIDTH = 6
);

    logic                                   i_clear;
    logic                                   i_write_en;
    logic [DATA_WIDTH-1:0]                  i_data;
    logic                                   i_pop_en;
    logic                                   i_flush;
    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] o_data;
    logic [DATA_LENGTH-1:0]                 o_valid;
    logic                                   o_out_valid;
    logic [COUNT_WIDTH-1:0]                 o_count;
    logic                                   o_row_avail;
    logic                                   o_empty;
    logic                                   o_full;

    modport master (
        output i_clear, i_write_en, i_data, i_pop_en, i_flush,
        input  o_data, o_valid, o_out_valid,
        input  o_count, o_row_avail, o_empty, o_full
    );

    modport slave (
        input  i_clear, i_write_en, i_data, i_pop_en, i_flush,
        output o_data, o_valid, o_out_valid,
        output o_count, o_row_avail, o_empty, o_full
    );

endinterface

// File: rtl/simo_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one write port, DATA_LENGTH read ports.
// Ports: i_clk, i_we/i_waddr/i_wdata write, i_rbase row base, o_rdata lanes.
module simo_fifo_mem #(
    parameter int DEPTH       = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 9,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                                   i_clk,
    input  logic                                   i_we,
    input  logic [ADDR_WIDTH-1:0]                  i_waddr,
    input  logic [DATA_WIDTH-1:0]                  i_wdata,
    input  logic [ADDR_WIDTH-1:0]                  i_rbase,
    output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Lane addresses wrap naturally in ADDR_WIDTH bits.
    for (genvar k = 0; k < DATA_LENGTH; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr       = i_rbase + ADDR_WIDTH'(k);
        assign o_rdata[k] = mem_q[addr];
    end

endmodule

// File: rtl/simo_fifo.sv
// SIMO FIFO: serial word writes, whole-row (or flushed partial) pops.
// Ports: i_clk, i_rst (async high), bus (simo_fifo_if.slave).
import router_pkg::*;

module simo_fifo #(
    parameter int DEPTH       = 32,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic     i_clk,
    input  logic     i_rst,
    simo_fifo_if.slave bus
);

    logic [ADDR_WIDTH-1:0]  w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0]  r_ptr_q, r_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_LENGTH-1:0] valid_q, valid_d;
    logic                   out_valid_q;

    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] rdata;
    logic [COUNT_WIDTH-1:0] pop_n;
    logic                   full;
    logic                   wr_acc;
    logic                   rd_acc;

    simo_fifo_mem #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_LENGTH (DATA_LENGTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_acc && !bus.i_clear),
        .i_waddr (w_ptr_q),
        .i_wdata (bus.i_data),
        .i_rbase (r_ptr_q),
        .o_rdata (rdata)
    );

    assign full   = (count_q == COUNT_WIDTH'(DEPTH));
    // Full is judged before the edge: a same-cycle pop frees nothing.
    assign wr_acc = bus.i_write_en && !full;

    always_comb begin
        pop_n = '0;
        if (bus.i_pop_en && count_q >= COUNT_WIDTH'(DATA_LENGTH)) begin
            pop_n = COUNT_WIDTH'(DATA_LENGTH);
        end else if (bus.i_pop_en && bus.i_flush && count_q != '0) begin
            pop_n = count_q;
        end
    end

    assign rd_acc = (pop_n != '0);

    always_comb begin
        data_d  = '0;
        valid_d = '0;
        for (int k = 0; k < DATA_LENGTH; k++) begin
            if (COUNT_WIDTH'(k) < pop_n) begin
                data_d[k]  = rdata[k];
                valid_d[k] = 1'b1;
            end
        end
    end

    assign w_ptr_d = w_ptr_q + ADDR_WIDTH'(wr_acc);
    assign r_ptr_d = r_ptr_q + ADDR_WIDTH'(pop_n);
    assign count_d = count_q + COUNT_WIDTH'(wr_acc) - pop_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.i_clear) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_count     = count_q;
    assign bus.o_row_avail = (count_q >= COUNT_WIDTH'(DATA_LENGTH));
    assign bus.o_empty     = (count_q == '0);
    assign bus.o_full      = full;

endmodule

// File: tb/tb_simo_fifo.sv
// Directed bench for simo_fifo: reset/clear, rows, flush, full, wrap.
// Expected rows are built from hand-chosen base values.
import router_pkg::*;

module tb_simo_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    simo_fifo_if #(
        .DATA_WIDTH  (8),
        .DATA_LENGTH (9),
        .COUNT_WIDTH (6)
    ) bus ();

    simo_fifo #(
        .DEPTH       (32),
        .DATA_WIDTH  (8),
        .DATA_LENGTH (9)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic row_t mk(input logic [7:0] base, input int n);
        row_t r;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            if (k < n) r[k] = base + 8'(k);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.i_write_en = 1'b1;
        bus.i_data     = d;
        tick();
        bus.i_write_en = 1'b0;
    endtask

    task automatic wr_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) wr(base + 8'(i));
    endtask

    task automatic pop(input logic f);
        bus.i_pop_en = 1'b1;
        bus.i_flush  = f;
        tick();
        bus.i_pop_en = 1'b0;
        bus.i_flush  = 1'b0;
    endtask

    initial begin
        bus.i_clear    = 1'b0;
        bus.i_write_en = 1'b0;
        bus.i_data     = '0;
        bus.i_pop_en   = 1'b0;
        bus.i_flush    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_count", 72'(bus.o_count), 72'd0);
        check("rst_empty", 72'(bus.o_empty), 72'd1);
        check("rst_full", 72'(bus.o_full), 72'd0);
        check("rst_valid", 72'(bus.o_valid), 72'd0);
        check("rst_data", bus.o_data, 72'd0);

        // async reset during a pop
        wr_seq(8'h40, 4);
        check("pre_rst_count", 72'(bus.o_count), 72'd4);
        bus.i_pop_en = 1'b1;
        bus.i_flush  = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_count", 72'(bus.o_count), 72'd0);
        tick();
        bus.i_pop_en = 1'b0;
        bus.i_flush  = 1'b0;
        rst = 1'b0;
        check("arst_ov", 72'(bus.o_out_valid), 72'd0);
        check("arst_valid", 72'(bus.o_valid), 72'd0);
        check("arst_empty", 72'(bus.o_empty), 72'd1);

        // clear beats write and pop
        wr_seq(8'h40, 4);
        bus.i_clear    = 1'b1;
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hEE;
        bus.i_pop_en   = 1'b1;
        bus.i_flush    = 1'b1;
        tick();
        bus.i_clear    = 1'b0;
        bus.i_write_en = 1'b0;
        bus.i_pop_en   = 1'b0;
        bus.i_flush    = 1'b0;
        check("clr_count", 72'(bus.o_count), 72'd0);
        check("clr_ov", 72'(bus.o_out_valid), 72'd0);
        check("clr_valid", 72'(bus.o_valid), 72'd0);

        // full row
        wr_seq(8'h01, 9);
        check("row_avail", 72'(bus.o_row_avail), 72'd1);
        pop(1'b0);
        check("row_data", bus.o_data, mk(8'h01, 9));
        check("row_valid", 72'(bus.o_valid), 72'h1FF);
        check("row_ov", 72'(bus.o_out_valid), 72'd1);
        check("row_count", 72'(bus.o_count), 72'd0);
        tick();
        check("row_ov_drop", 72'(bus.o_out_valid), 72'd0);
        check("row_hold", bus.o_data, mk(8'h01, 9));

        // partial then flush
        wr_seq(8'hA0, 5);
        check("part_avail", 72'(bus.o_row_avail), 72'd0);
        pop(1'b0);
        check("part_ign_ov", 72'(bus.o_out_valid), 72'd0);
        check("part_ign_cnt", 72'(bus.o_count), 72'd5);
        pop(1'b1);
        check("flush_data", bus.o_data, mk(8'hA0, 5));
        check("flush_valid", 72'(bus.o_valid), 72'h01F);
        check("flush_count", 72'(bus.o_count), 72'd0);
        pop(1'b1);
        check("flush_empty_ov", 72'(bus.o_out_valid), 72'd0);

        // full boundary; rows straddle wrap (r_ptr starts at 14)
        wr_seq(8'h00, 33);
        check("full_flag", 72'(bus.o_full), 72'd1);
        check("full_count", 72'(bus.o_count), 72'd32);
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h99;
        pop(1'b0);
        bus.i_write_en = 1'b0;
        check("full_r0", bus.o_data, mk(8'h00, 9));
        check("full_wr_rej", 72'(bus.o_count), 72'd23);
        pop(1'b0);
        check("full_r1", bus.o_data, mk(8'h09, 9));
        pop(1'b0);
        check("full_r2", bus.o_data, mk(8'h12, 9));
        check("full_left", 72'(bus.o_count), 72'd5);
        pop(1'b1);
        check("full_tail", bus.o_data, mk(8'h1B, 5));

        // wrap from r_ptr = 27
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        wr_seq(8'h60, 27);
        pop(1'b0);
        pop(1'b0);
        pop(1'b0);
        check("wrap_pre", bus.o_data, mk(8'h72, 9));
        wr_seq(8'h50, 9);
        pop(1'b0);
        check("wrap_data", bus.o_data, mk(8'h50, 9));
        check("wrap_valid", 72'(bus.o_valid), 72'h1FF);

        // simultaneous write and pop
        wr_seq(8'h10, 9);
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h77;
        pop(1'b0);
        bus.i_write_en = 1'b0;
        check("sim_data", bus.o_data, mk(8'h10, 9));
        check("sim_count", 72'(bus.o_count), 72'd1);
        pop(1'b1);
        check("sim_flush", bus.o_data, mk(8'h77, 1));
        check("sim_valid", 72'(bus.o_valid), 72'h001);
        check("sim_empty", 72'(bus.o_empty), 72'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
